spi_display_rx: RTL and testbench
=================================

SPI_DISPLAY_RX -- requirements
Module: spi_display_rx

Interface
REQ-001 Parameter WIDTH, default 240, panel columns.
REQ-002 Parameter HEIGHT, default 320, panel rows.
REQ-003 Parameter AW, default clog2(WIDTH*HEIGHT), pixel address width.
REQ-004 i_clk  input  1  single clock; serial bit clock is i_clk itself, one bit per rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_mosi  input  1  serial data, MSB first.
REQ-007 i_dc  input  1  0 = command byte, 1 = data byte.
REQ-008 i_cs  input  1  active-low chip select.
REQ-009 o_cmd  output  8  last received command byte.
REQ-010 o_cmd_valid  output  1  one-cycle pulse per received command.
REQ-011 o_pix_we  output  1  one-cycle pixel write strobe.
REQ-012 o_pix_addr  output  AW  row*WIDTH + col of written pixel.
REQ-013 o_pix_data  output  16  RGB565 pixel.
REQ-014 o_frame_done  output  1  one-cycle pulse when the last pixel of the window is written.

Function
REQ-015 A bit SHALL be shifted in on each i_clk edge with i_cs=0; 8 bits form one byte; i_dc is sampled with the 8th bit.
REQ-016 i_cs=1 SHALL discard any partial byte (bit counter to 0); decoder state and window SHALL be kept.
REQ-017 Decoder states: IDLE, CASET, PASET, RAMWR, IGNORE.
REQ-018 A command byte SHALL set o_cmd and pulse o_cmd_valid the cycle after its 8th bit, abort any state, and clear the argument counter.
REQ-019 Command 0x2A -> CASET; 0x2B -> PASET; 0x2C -> RAMWR; any other -> IGNORE.
REQ-020 CASET/PASET SHALL take 4 data bytes: start[15:8], start[7:0], end[15:8], end[7:0]; window registers update after byte 4; state -> IDLE; further data bytes ignored.
REQ-021 Entering RAMWR SHALL set col=col_start, row=row_start, byte phase=high.
REQ-022 In RAMWR, data bytes pair high then low; after the low byte, o_pix_we pulses the next cycle with o_pix_data={high,low} and o_pix_addr of current (col,row).
REQ-023 After each pixel: col<col_end -> col+1; else col=col_start and row<row_end -> row+1; else row=row_start with o_frame_done pulsed in the same cycle as that o_pix_we.
REQ-024 Pixels with col>=WIDTH or row>=HEIGHT SHALL advance the cursor but suppress o_pix_we.
REQ-025 start>end on either axis: cursor SHALL stay at start and wrap every pixel on that axis.
REQ-026 Data bytes in IDLE or IGNORE SHALL be discarded without effect.
REQ-027 A single pending high byte at a command or i_cs=1 SHALL be dropped (no write).
REQ-028 Address arithmetic SHALL use full 16-bit col/row, product truncated to AW bits only after range check.

Reset
REQ-029 On i_rst: state IDLE, bit counter 0, shift register 0, all outputs 0.
REQ-030 On i_rst: window col 0..WIDTH-1, row 0..HEIGHT-1; cursor at 0,0.
REQ-031 Reset mid-byte or mid-RAMWR SHALL drop all partial data; no strobe the following cycle.

Structure
REQ-032 Package spi_display_pkg SHALL hold command constants (0x2A, 0x2B, 0x2C) and the decoder state encoding, shared with the transmitter blocks.
REQ-033 Sub-module spi_byte_rx SHALL perform bit shifting, byte completion and dc capture, giving a byte_valid/byte/is_data handshake to the decoder.

Verification
REQ-034 Send cmd 0x2C, data 0xF8,0x00 -> o_cmd_valid with o_cmd=0x2C; then o_pix_we, addr 0, data 0xF800.
REQ-035 CASET 0,2,0,3; PASET 0,5,0,6; RAMWR 4 pixels (WIDTH=24) -> addrs 122,123,146,147; o_frame_done with 4th.
REQ-036 CASET 0,22,0,25 (WIDTH=24), RAMWR 4 pixels -> writes at cols 22,23 only; cols 24,25 suppressed.
REQ-037 i_cs high after 5 bits of a data byte, then full byte 0x12,0x34 -> single pixel 0x1234.
REQ-038 i_rst during RAMWR after high byte -> all outputs 0; next RAMWR starts at addr 0.
REQ-039 Unknown cmd 0x11 then 3 data bytes -> o_cmd_valid, o_cmd=0x11, no o_pix_we.

Source files
------------

// File: rtl/spi_display_pkg.sv
// Shared command codes and decoder state encoding for the SPI display link.
package spi_display_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_IGNORE
    } dec_state_e;

    function automatic dec_state_e cmd_to_state(input logic [7:0] cmd);
        case (cmd)
            CMD_CASET: return ST_CASET;
            CMD_PASET: return ST_PASET;
            CMD_RAMWR: return ST_RAMWR;
            default:   return ST_IGNORE;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Serial-to-byte deserialiser; byte_valid is combinational on the 8th bit edge.
module spi_byte_rx
    import spi_display_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_mosi,
    input  logic       i_dc,
    input  logic       i_cs,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_is_data
);

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        o_byte_valid = 1'b0;
        if (i_cs) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end else begin
            shift_d      = {shift_q[5:0], i_mosi};
            bit_cnt_d    = bit_cnt_q + 3'd1;
            o_byte_valid = (bit_cnt_q == 3'd7);
        end
    end

    assign o_byte    = {shift_q, i_mosi};
    assign o_is_data = i_dc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/spi_display_rx.sv
// Display-controller receiver: decodes CASET/PASET/RAMWR and streams pixel writes.
module spi_display_rx
    import spi_display_pkg::*;
#(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320,
    parameter int AW     = $clog2(WIDTH * HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_mosi,
    input  logic          i_dc,
    input  logic          i_cs,
    output logic [7:0]    o_cmd,
    output logic          o_cmd_valid,
    output logic          o_pix_we,
    output logic [AW-1:0] o_pix_addr,
    output logic [15:0]   o_pix_data,
    output logic          o_frame_done
);

    localparam logic [31:0] W32 = 32'(WIDTH);
    localparam logic [31:0] H32 = 32'(HEIGHT);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_is_data;

    spi_byte_rx u_byte_rx (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_mosi       (i_mosi),
        .i_dc         (i_dc),
        .i_cs         (i_cs),
        .o_byte_valid (rx_valid),
        .o_byte       (rx_byte),
        .o_is_data    (rx_is_data)
    );

    dec_state_e     state_q, state_d;
    logic [1:0]     arg_cnt_q, arg_cnt_d;
    logic [23:0]    arg_q, arg_d;
    logic [15:0]    col_start_q, col_start_d, col_end_q, col_end_d;
    logic [15:0]    row_start_q, row_start_d, row_end_q, row_end_d;
    logic [15:0]    col_q, col_d, row_q, row_d;
    logic           hi_pend_q, hi_pend_d;
    logic [7:0]     hi_byte_q, hi_byte_d;
    logic [7:0]     cmd_q, cmd_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic           pix_we_q, pix_we_d;
    logic [AW-1:0]  pix_addr_q, pix_addr_d;
    logic [15:0]    pix_data_q, pix_data_d;
    logic           frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        arg_cnt_d    = arg_cnt_q;
        arg_d        = arg_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        row_start_d  = row_start_q;
        row_end_d    = row_end_q;
        col_d        = col_q;
        row_d        = row_q;
        hi_pend_d    = hi_pend_q;
        hi_byte_d    = hi_byte_q;
        cmd_d        = cmd_q;
        cmd_valid_d  = 1'b0;
        pix_we_d     = 1'b0;
        pix_addr_d   = pix_addr_q;
        pix_data_d   = pix_data_q;
        frame_done_d = 1'b0;

        if (i_cs) begin
            hi_pend_d = 1'b0;
        end else if (rx_valid && !rx_is_data) begin
            cmd_d       = rx_byte;
            cmd_valid_d = 1'b1;
            state_d     = cmd_to_state(rx_byte);
            arg_cnt_d   = '0;
            hi_pend_d   = 1'b0;
            col_d       = col_start_q;
            row_d       = row_start_q;
        end else if (rx_valid) begin
            case (state_q)
                ST_CASET, ST_PASET: begin
                    if (arg_cnt_q == 2'd3) begin
                        if (state_q == ST_CASET) begin
                            col_start_d = arg_q[23:8];
                            col_end_d   = {arg_q[7:0], rx_byte};
                        end else begin
                            row_start_d = arg_q[23:8];
                            row_end_d   = {arg_q[7:0], rx_byte};
                        end
                        state_d = ST_IDLE;
                    end else begin
                        arg_d     = {arg_q[15:0], rx_byte};
                        arg_cnt_d = arg_cnt_q + 2'd1;
                    end
                end
                ST_RAMWR: begin
                    if (!hi_pend_q) begin
                        hi_byte_d = rx_byte;
                        hi_pend_d = 1'b1;
                    end else begin
                        hi_pend_d  = 1'b0;
                        pix_data_d = {hi_byte_q, rx_byte};
                        // Range check on full 16-bit cursor before narrowing the address.
                        pix_we_d   = (32'(col_q) < W32) && (32'(row_q) < H32);
                        if (pix_we_d) begin
                            pix_addr_d = AW'(32'(row_q) * W32 + 32'(col_q));
                        end
                        if (col_q < col_end_q) begin
                            col_d = col_q + 16'd1;
                        end else begin
                            col_d = col_start_q;
                            if (row_q < row_end_q) begin
                                row_d = row_q + 16'd1;
                            end else begin
                                row_d        = row_start_q;
                                frame_done_d = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            arg_cnt_q    <= '0;
            arg_q        <= '0;
            col_start_q  <= '0;
            col_end_q    <= 16'(WIDTH - 1);
            row_start_q  <= '0;
            row_end_q    <= 16'(HEIGHT - 1);
            col_q        <= '0;
            row_q        <= '0;
            hi_pend_q    <= 1'b0;
            hi_byte_q    <= '0;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            pix_we_q     <= 1'b0;
            pix_addr_q   <= '0;
            pix_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            arg_cnt_q    <= arg_cnt_d;
            arg_q        <= arg_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            row_start_q  <= row_start_d;
            row_end_q    <= row_end_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hi_pend_q    <= hi_pend_d;
            hi_byte_q    <= hi_byte_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            pix_we_q     <= pix_we_d;
            pix_addr_q   <= pix_addr_d;
            pix_data_q   <= pix_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_cmd        = cmd_q;
    assign o_cmd_valid  = cmd_valid_q;
    assign o_pix_we     = pix_we_q;
    assign o_pix_addr   = pix_addr_q;
    assign o_pix_data   = pix_data_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_display_rx.sv
// Scoreboard bench: a transaction-level panel model predicts every output event.
module tb_spi_display_rx;

    localparam int W  = 24;
    localparam int H  = 32;
    localparam int AW = $clog2(W * H);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mosi = 1'b0;
    logic          dc = 1'b0;
    logic          cs = 1'b1;
    logic [7:0]    o_cmd;
    logic          o_cmd_valid;
    logic          o_pix_we;
    logic [AW-1:0] o_pix_addr;
    logic [15:0]   o_pix_data;
    logic          o_frame_done;

    spi_display_rx #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mosi       (mosi),
        .i_dc         (dc),
        .i_cs         (cs),
        .o_cmd        (o_cmd),
        .o_cmd_valid  (o_cmd_valid),
        .o_pix_we     (o_pix_we),
        .o_pix_addr   (o_pix_addr),
        .o_pix_data   (o_pix_data),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_cmd;
        logic [7:0]  cmd;
        bit          we;
        int unsigned addr;
        logic [15:0] data;
        bit          fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Panel model: mode 0 = nothing to do, 1 = column window, 2 = row window, 3 = memory write.
    int          m_mode;
    logic [7:0]  m_args[$];
    int unsigned m_cs, m_ce, m_rs, m_re, m_col, m_row;
    bit          m_hi_pend;
    logic [7:0]  m_hi;

    function automatic void model_reset();
        m_mode = 0;
        m_args.delete();
        m_cs = 0; m_ce = W - 1; m_rs = 0; m_re = H - 1;
        m_col = 0; m_row = 0;
        m_hi_pend = 0; m_hi = 8'h00;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit is_data);
        exp_t e;
        int unsigned s, en;
        e = '{is_cmd: 0, cmd: 8'h00, we: 0, addr: 0, data: 16'h0000, fd: 0};
        if (!is_data) begin
            e.is_cmd = 1; e.cmd = b;
            exp_q.push_back(e);
            m_hi_pend = 0;
            m_args.delete();
            m_mode = (b == 8'h2A) ? 1 : (b == 8'h2B) ? 2 : (b == 8'h2C) ? 3 : 0;
            if (m_mode == 3) begin
                m_col = m_cs; m_row = m_rs;
            end
        end else if (m_mode == 1 || m_mode == 2) begin
            m_args.push_back(b);
            if (m_args.size() == 4) begin
                s  = m_args[0] * 256 + m_args[1];
                en = m_args[2] * 256 + m_args[3];
                if (m_mode == 1) begin m_cs = s; m_ce = en; end
                else begin m_rs = s; m_re = en; end
                m_mode = 0;
            end
        end else if (m_mode == 3) begin
            if (!m_hi_pend) begin
                m_hi = b; m_hi_pend = 1;
            end else begin
                m_hi_pend = 0;
                e.data = {m_hi, b};
                e.we   = (m_col < W) && (m_row < H);
                e.addr = m_row * W + m_col;
                if (m_col < m_ce) m_col++;
                else begin
                    m_col = m_cs;
                    if (m_row < m_re) m_row++;
                    else begin m_row = m_rs; e.fd = 1; end
                end
                if (e.we || e.fd) exp_q.push_back(e);
            end
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit ok;
        if (o_cmd_valid || o_pix_we || o_frame_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got cv=%0b cmd=%02h we=%0b addr=%0d data=%04h fd=%0b, required no event",
                         o_cmd_valid, o_cmd, o_pix_we, o_pix_addr, o_pix_data, o_frame_done);
            end else begin
                e = exp_q.pop_front();
                ok = (e.is_cmd == o_cmd_valid) && (!e.is_cmd || o_cmd == e.cmd)
                     && (e.we == o_pix_we) && (!e.we || (o_pix_addr == AW'(e.addr) && o_pix_data == e.data))
                     && (e.fd == o_frame_done);
                if (!ok) begin
                    errors++;
                    $display("FAIL event_%s: got cv=%0b cmd=%02h we=%0b addr=%0d data=%04h fd=%0b, required cv=%0b cmd=%02h we=%0b addr=%0d data=%04h fd=%0b",
                             e.is_cmd ? "cmd" : "pix", o_cmd_valid, o_cmd, o_pix_we, o_pix_addr, o_pix_data,
                             o_frame_done, e.is_cmd, e.cmd, e.we, e.addr, e.data, e.fd);
                end
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input bit d, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            cs = 1'b0; mosi = b[i]; dc = d;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit d);
        send_bits(b, d, 8);
        model_byte(b, d);
    endtask

    task automatic cs_gap(input int n);
        cs = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        m_hi_pend = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({o_cmd, o_cmd_valid, o_pix_we, o_pix_addr, o_pix_data, o_frame_done} != '0) begin
            errors++;
            $display("FAIL reset_outputs: got cmd=%02h cv=%0b we=%0b addr=%0d data=%04h fd=%0b, required all 0",
                     o_cmd, o_cmd_valid, o_pix_we, o_pix_addr, o_pix_data, o_frame_done);
        end
        rst = 1'b0;
        exp_q.delete();
        model_reset();
    endtask

    task automatic window(input logic [7:0] c, input int s, input int e);
        logic [15:0] sv, ev;
        sv = 16'(s); ev = 16'(e);
        send_byte(c, 0);
        send_byte(sv[15:8], 1); send_byte(sv[7:0], 1);
        send_byte(ev[15:8], 1); send_byte(ev[7:0], 1);
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(8'($urandom), 1);
            send_byte(8'($urandom), 1);
        end
    endtask

    initial begin
        logic [7:0] b;
        int op;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        send_byte(8'h2C, 0); send_byte(8'hF8, 1); send_byte(8'h00, 1);

        window(8'h2A, 2, 3); window(8'h2B, 5, 6);
        send_byte(8'h2C, 0); pixels(4);

        do_reset();
        window(8'h2A, 22, 25);
        send_byte(8'h2C, 0); pixels(4);

        send_byte(8'h2C, 0);
        send_bits(8'hA5, 1, 5); cs_gap(2);
        send_byte(8'h12, 1); send_byte(8'h34, 1);

        send_byte(8'h2C, 0); send_byte(8'hAB, 1);
        do_reset();
        send_byte(8'h2C, 0); send_byte(8'h55, 1); send_byte(8'hAA, 1);

        send_byte(8'h11, 0); send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1);

        window(8'h2A, 5, 2); window(8'h2B, 3, 3);
        send_byte(8'h2C, 0); pixels(3);

        send_bits(8'h3C, 1, 4);
        do_reset();

        for (int k = 0; k < 400; k++) begin
            op = $urandom_range(0, 99);
            if (op < 12) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: b = 8'h2A;
                    3, 4, 5: b = 8'h2B;
                    6, 7, 8: b = 8'h2C;
                    default: b = 8'($urandom);
                endcase
                send_byte(b, 0);
            end else if (op < 85) begin
                if (m_mode == 1 || m_mode == 2)
                    b = (m_args.size() % 2 == 0) ? (($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00)
                                                 : 8'($urandom_range(0, 40));
                else
                    b = 8'($urandom);
                send_byte(b, 1);
            end else if (op < 93) begin
                cs_gap($urandom_range(1, 3));
            end else if (op < 98) begin
                send_bits(8'($urandom), 1'($urandom), $urandom_range(1, 7));
                cs_gap($urandom_range(1, 2));
            end else begin
                do_reset();
            end
        end

        cs_gap(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
